// File: rtl/daq_pkg.sv
// Shared types and constants for the sample packetizer datapath.
package daq_pkg;

  // Packet framing states, in on-the-wire byte order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM
  } pkt_state_t;

  // Default first byte of every packet.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Bytes per packet: sync, sequence, two bytes per sample, checksum.
  function automatic int unsigned pkt_len(input int unsigned n_samples);
    return 2 * n_samples + 3;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the head entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_en, rd_en;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sample_packetizer.sv
// Frames buffered ADC samples into fixed-length byte packets
// (sync, seq, hi/lo per sample, XOR checksum) on a valid/ready byte stream.
module sample_packetizer
  import daq_pkg::*;
#(
  parameter int         SAMPLE_W        = 12,
  parameter int         SAMPLES_PER_PKT = 8,
  parameter int         FIFO_DEPTH      = 16,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           sample_data,
  input  logic                          sample_valid,
  output logic [7:0]                    byte_data,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          pkt_start,
  output logic                          pkt_end,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count,
  output logic                          busy
);

  localparam int CW = $clog2(SAMPLES_PER_PKT) + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  pkt_state_t          state_q, state_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          csum_q, csum_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         ovf_q, ovf_d;

  logic [SAMPLE_W-1:0] fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [15:0]         head16;
  logic                accept, push, pop;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100MHz),
    .srst  (reset),
    .push  (push),
    .pop   (pop),
    .din   (sample_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign overflow_count = ovf_q;

  // Output decode from state, then next-state, checksum, counters and FIFO control.
  always_comb begin
    head16     = 16'(fifo_dout);
    byte_valid = (state_q != ST_IDLE);
    busy       = (state_q != ST_IDLE);
    pkt_start  = (state_q == ST_SYNC);
    pkt_end    = (state_q == ST_CSUM);
    case (state_q)
      ST_SYNC:    byte_data = SYNC_BYTE;
      ST_SEQ:     byte_data = seq_q;
      ST_DATA_HI: byte_data = head16[15:8];
      ST_DATA_LO: byte_data = head16[7:0];
      ST_CSUM:    byte_data = csum_q;
      default:    byte_data = 8'h00;
    endcase

    accept = byte_valid && byte_ready;
    // The sample leaves the FIFO once its low byte has been taken.
    pop    = accept && (state_q == ST_DATA_LO) && !fifo_empty;
    push   = sample_valid && (!fifo_full || pop);

    state_d = state_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (sample_valid && !push && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        // Start only when a whole packet is buffered, so the FSM can never underflow.
        if (fifo_level >= LW'(SAMPLES_PER_PKT)) begin
          state_d = ST_SYNC;
          csum_d  = 8'h00;
          cnt_d   = '0;
        end
      end
      ST_SYNC: if (accept) state_d = ST_SEQ;
      ST_SEQ: begin
        if (accept) begin
          csum_d  = csum_q ^ seq_q;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          csum_d  = csum_q ^ byte_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          csum_d = csum_q ^ byte_data;
          if (cnt_q == CW'(SAMPLES_PER_PKT - 1)) begin
            state_d = ST_CSUM;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          seq_d   = seq_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seq_q   <= 8'h00;
      csum_q  <= 8'h00;
      cnt_q   <= '0;
      ovf_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sample_packetizer.sv
// Randomized bench for sample_packetizer against a queue-based packet model.
module tb_sample_packetizer;
  import daq_pkg::*;

  localparam int SW    = 12;
  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int L     = pkt_len(N);

  logic          clk_100MHz = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] sample_data = '0;
  logic          sample_valid = 1'b0;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic          pkt_start, pkt_end;
  logic [4:0]    fifo_level;
  logic [15:0]   overflow_count;
  logic          busy;

  always #5 clk_100MHz = ~clk_100MHz;

  sample_packetizer #(
    .SAMPLE_W        (SW),
    .SAMPLES_PER_PKT (N),
    .FIFO_DEPTH      (DEPTH),
    .SYNC_BYTE       (8'hA5)
  ) dut (
    .clk_100MHz     (clk_100MHz),
    .reset          (reset),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .pkt_start      (pkt_start),
    .pkt_end        (pkt_end),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count),
    .busy           (busy)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: buffered samples, byte position in current packet (-1 = idle), expected packet.
  int m_q[$];
  int m_pos = -1;
  int m_seq = 0;
  int m_ovf = 0;
  int m_pkt[L];
  int pkts_done = 0;
  int last_csum = -1;
  int last_seq_byte = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_pkt();
    int c;
    int s;
    m_pkt[0] = 8'hA5;
    m_pkt[1] = m_seq;
    c = m_seq;
    for (int k = 0; k < N; k++) begin
      s = m_q[k] & 16'hFFFF;
      m_pkt[2 + 2 * k] = s >> 8;
      m_pkt[3 + 2 * k] = s & 8'hFF;
      c = c ^ (s >> 8) ^ (s & 8'hFF);
    end
    m_pkt[L - 1] = c;
  endtask

  task automatic compare_outputs();
    check_val("byte_valid", byte_valid, (m_pos >= 0));
    check_val("busy", busy, (m_pos >= 0));
    check_val("fifo_level", fifo_level, m_q.size());
    check_val("overflow_count", overflow_count, m_ovf);
    if (m_pos >= 0) begin
      check_val("byte_data", byte_data, m_pkt[m_pos]);
      check_val("pkt_start", pkt_start, (m_pos == 0));
      check_val("pkt_end", pkt_end, (m_pos == L - 1));
    end else begin
      check_val("pkt_start_idle", pkt_start, 0);
      check_val("pkt_end_idle", pkt_end, 0);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, advance model, check after the next rise.
  task automatic step(input bit sv, input int d, input bit rdy);
    bit acc;
    bit pop;
    int dm;
    dm = d & ((1 << SW) - 1);
    sample_valid = sv;
    sample_data  = dm[SW-1:0];
    byte_ready   = rdy;
    acc = (m_pos >= 0) && rdy;
    pop = acc && (m_pos >= 3) && (m_pos <= L - 2) && (m_pos % 2 == 1);
    if (acc && m_pos == 1) last_seq_byte = byte_data;
    if (acc) begin
      if (m_pos == L - 1) begin
        last_csum = byte_data;
        m_seq = (m_seq + 1) % 256;
        m_pos = -1;
        pkts_done++;
      end else begin
        m_pos++;
      end
    end else if (m_pos < 0 && m_q.size() >= N) begin
      build_pkt();
      m_pos = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (sv) begin
      if (m_q.size() < DEPTH) m_q.push_back(dm);
      else if (m_ovf < 65535) m_ovf++;
    end
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    byte_ready   = 1'b0;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    reset = 1'b0;
    m_q.delete();
    m_pos = -1;
    m_seq = 0;
    m_ovf = 0;
    compare_outputs();
    check_val("rst_byte_data", byte_data, 0);
  endtask

  initial begin
    int n;
    int pk0;
    int p_sv;
    int p_rdy;
    bit found;

    @(negedge clk_100MHz);
    do_reset();

    // Single packet of samples 1..8 with the sink always ready.
    for (int i = 1; i <= N; i++) step(1'b1, i, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 0, 1'b1);
    check_val("single_csum", last_csum, 8'h08);

    // Byte split: 0xABC then seven zero samples.
    do_reset();
    step(1'b1, 'hABC, 1'b1);
    for (int i = 1; i < N; i++) step(1'b1, 0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 0, 1'b1);
    check_val("split_csum", last_csum, 8'hB6);

    // Backpressure held for 5 cycles while sample 3's high byte is presented.
    do_reset();
    for (int i = 1; i <= N; i++) step(1'b1, i, 1'b1);
    n = 0;
    while (m_pos != 6 && n < 50) begin
      step(1'b0, 0, 1'b1);
      n++;
    end
    check_val("bp_reach", m_pos, 6);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 0, 1'b1);
    check_val("bp_csum", last_csum, 8'h08);

    // Overflow with the sink stalled: 20 pushes into a 16-deep FIFO.
    do_reset();
    pk0 = pkts_done;
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0);
    check_val("ovf_level", fifo_level, 16);
    check_val("ovf_count", overflow_count, 4);
    check_val("ovf_busy", busy, 1);
    check_val("ovf_sync_held", pkt_start, 1);
    for (int i = 0; i < 60; i++) step(1'b0, 0, 1'b1);
    check_val("ovf_pkts", pkts_done - pk0, 2);
    check_val("ovf_last_seq", last_seq_byte, 8'h01);

    // Random traffic with varying sample rate and sink readiness.
    for (int blk = 0; blk < 15; blk++) begin
      p_sv  = $urandom_range(10, 100);
      p_rdy = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++)
        step(($urandom_range(1, 100) <= p_sv), $urandom, ($urandom_range(1, 100) <= p_rdy));
    end

    // Sequence wrap: stream well past 256 packets.
    do_reset();
    pk0 = pkts_done;
    n = 0;
    while ((pkts_done - pk0) < 258 && n < 20000) begin
      step(($urandom_range(0, 1) == 1), $urandom, ($urandom_range(1, 10) != 1));
      n++;
    end
    check_val("wrap_pkts_reached", ((pkts_done - pk0) >= 258), 1);
    check_val("wrap_seq_byte", last_seq_byte, 8'h01);

    // Reset while a low data byte is on the output.
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      step(($urandom_range(1, 10) <= 7), $urandom, $urandom_range(0, 1));
      found = (m_pos >= 3) && (m_pos <= L - 2) && (m_pos % 2 == 1);
      n++;
    end
    check_val("midrst_reach", found, 1);
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 0, 1'b1);
    check_val("midrst_seq", last_seq_byte, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sample_packetizer.md
Name: sample_packetizer

Overview:
- Downstream stage of the acquisition control FSM. Consumes each processed ADC sample, qualified by that FSM's proc_data_valid pulse.
- Buffers samples in a small FIFO and frames them into fixed-length byte packets: sync, sequence, sample bytes, checksum.
- Streams the packets over a valid/ready byte interface to the UART TX / nRF24L01+ transmit path.
- The sample input has no backpressure, so samples that arrive when the FIFO is full are dropped and counted.

Parameters:
- SAMPLE_W, 12: sample width in bits; legal range 9..16.
- SAMPLES_PER_PKT, 8: samples per packet (N); must be ≤ FIFO_DEPTH.
- FIFO_DEPTH, 16: sample FIFO depth; must be a power of 2.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk_100MHz, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- sample_data, in, SAMPLE_W: processed ADC sample.
- sample_valid, in, 1: single-cycle strobe (proc_data_valid).
- byte_data, out, 8: outgoing packet byte.
- byte_valid, out, 1: byte_data is valid.
- byte_ready, in, 1: sink accepts the byte this cycle.
- pkt_start, out, 1: high while the SYNC byte is presented.
- pkt_end, out, 1: high while the checksum byte is presented.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- overflow_count, out, 16: number of dropped samples; saturates at 16'hFFFF.
- busy, out, 1: FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk_100MHz. reset is synchronous and active-high.
- Reset values: byte_valid=0, byte_data=0, pkt_start=0, pkt_end=0, busy=0, fifo_level=0, overflow_count=0, seq=0. FIFO pointers cleared, FSM in IDLE.
- Reset mid-packet aborts the packet. Buffered samples are discarded, and no partial packet resumes afterwards.
- Write side:
  - push = sample_valid && (!full || pop_this_cycle).
  - If sample_valid is high and the push is refused, overflow_count increments (saturating).
  - Simultaneous push and pop leaves fifo_level unchanged.
- Packet format, 2N+3 bytes:
  - SYNC_BYTE, then seq[7:0].
  - Then per sample, a high byte and a low byte. The sample is zero-extended to 16 bits and sent MSB byte first.
  - Then CSUM = XOR of seq and all sample bytes. SYNC_BYTE is excluded from the checksum.
- FSM states: IDLE, SYNC, SEQ, DATA_HI, DATA_LO, CSUM.
  - IDLE → SYNC when fifo_level ≥ N. byte_valid rises on the next clock edge, giving 1 cycle of latency.
  - SYNC → SEQ on accept.
  - SEQ → DATA_HI on accept.
  - DATA_HI → DATA_LO on accept.
  - DATA_LO → DATA_HI on accept while samples_sent < N-1; → CSUM on accept of the Nth sample.
  - CSUM → IDLE on accept. seq increments and wraps 8'hFF → 8'h00.
- Accept means byte_valid && byte_ready.
- While byte_valid=1 and byte_ready=0, byte_data, pkt_start and pkt_end hold stable.
- Back-to-back packets: CSUM → IDLE → SYNC costs one idle cycle minimum.
- The FIFO head is read combinationally (show-ahead). It is popped on accept of the DATA_LO byte. N samples are guaranteed present for the whole packet, so the FSM never underflows.
- The checksum accumulator clears on entering SYNC and updates on each accepted SEQ/DATA byte.
- Width rule: the sample counter is $clog2(SAMPLES_PER_PKT)+1 bits wide. Sample bits above SAMPLE_W are forced to 0.

Decomposition:
- Package daq_pkg:
  - state typedef pkt_state_t.
  - SYNC_BYTE default constant.
  - Helper function computing the packet length, 2N+3.
- Sub-module sample_fifo:
  - Synchronous, show-ahead, parameterised by width and depth.
  - Ports: push, pop, din, dout, full, empty, level.
  - Simultaneous push and pop is allowed when full.

Test Plan:
- Single packet: N=8, samples 0x001..0x008, byte_ready=1 → 19 bytes A5,00,00,01,00,02,…,00,08,08. pkt_start on byte 0 only, pkt_end on byte 18 only. First byte_valid appears 1 cycle after fifo_level reaches 8.
- Byte split: sample 0xABC plus 7 zero samples → bytes 0A,BC,…; CSUM = 00^0A^BC = B6.
- Backpressure: drop byte_ready for 5 cycles during DATA_HI of sample 3 → byte_data stable for all 5 cycles, no duplicate or lost bytes, stream matches scenario 1.
- Overflow: byte_ready=0, push 20 samples → fifo_level=16, overflow_count=4, busy=1, SYNC held on the output. Release byte_ready → two packets emitted with seq 00 and 01.
- Sequence wrap: stream 257 packets → seq byte …,FE,FF,00; the checksum of each packet reflects its seq.
- Reset mid-packet: assert reset for 1 cycle in DATA_LO → next cycle byte_valid=0, fifo_level=0, overflow_count=0. The next packet starts with seq 00.
